hazard_scoreboard: RTL and testbench

//  Parametrised stall/forward controller for the NSTAGE-deep MIPS pipeline.
//  - Tracks every in-flight GPR write (dest, Tnew) from E to W in a shift register of slots.
//  - Compares D-stage source registers against the slots; emits stall and per-operand forward selects.
//  - Models MDU busy time, so mfhi/mflo/mthi/mtlo/mult/div behind a running mult/div stall in D.
//  - Replaces the per-instruction Tuse/new_at wiring with one registered, stage-count-generic unit.

---
 rtl/hazard_scoreboard_pkg.sv | 28 ++
 rtl/hazard_scoreboard_if.sv | 34 +++
 rtl/hazard_scoreboard_md_ctr.sv | 29 ++
 rtl/hazard_scoreboard.sv | 137 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the hazard scoreboard: Tnew/Tuse codes,
// forward-select codes and MDU latency defaults.
package hazard_scoreboard_pkg;

  localparam logic [1:0] TUSE_NONE = 2'b11;
  localparam logic [1:0] TNEW_PC   = 2'd0;
  localparam logic [1:0] TNEW_CAL  = 2'd1;
  localparam logic [1:0] TNEW_DM   = 2'd2;

  localparam logic [2:0] FWD_GRF = 3'd0;
  localparam logic [2:0] FWD_E   = 3'd1;
  localparam logic [2:0] FWD_M   = 3'd2;
  localparam logic [2:0] FWD_W   = 3'd3;

  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

  typedef struct packed {
    logic       stall;
    logic [2:0] sel;
  } fwd_res_t;

  // Slot k forwards with select code k+1; code 0 is the register file.
  function automatic logic [2:0] fwd_code(input int unsigned slot);
    return 3'(slot + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard query bundle: the pipeline (master) presents the decoded
// instruction, the scoreboard (slave) answers with stall/forward controls.
interface hazard_scoreboard_if #(
  parameter int unsigned RW = 5,
  parameter int unsigned TW = 2
);
  logic          d_valid;
  logic [RW-1:0] d_rs;
  logic [RW-1:0] d_rt;
  logic [TW-1:0] d_tuse_rs;
  logic [TW-1:0] d_tuse_rt;
  logic [RW-1:0] d_a3;
  logic [TW-1:0] d_tnew;
  logic          d_md_start;
  logic          d_md_div;
  logic          d_md_use;
  logic          flush;
  logic          stall;
  logic [2:0]    fwd_rs_sel;
  logic [2:0]    fwd_rt_sel;
  logic          md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew,
           d_md_start, d_md_div, d_md_use, flush,
    input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew,
           d_md_start, d_md_div, d_md_use, flush,
    output stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard_md_ctr.sv
// MDU busy counter: loads the mult/div latency when an MDU op leaves E,
// then counts down to zero; busy while nonzero.
module hsb_md_ctr #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic is_div,
  output logic busy
);
  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/forward controller: tracks in-flight GPR writes from E to W in a
// slot shift register and resolves D-stage operand hazards against them.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NSTAGE   = 3,
  parameter int unsigned TW       = 2,
  parameter int unsigned RW       = 5,
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input logic               clk,
  input logic               reset,
  hazard_scoreboard_if.slave hs
);
  localparam logic [TW-1:0] TUSE_ALL = '1;

  logic [NSTAGE-1:0]         slot_valid;
  logic [NSTAGE-1:0][RW-1:0] slot_a3;
  logic [NSTAGE-1:0][TW-1:0] slot_tnew;
  logic [NSTAGE-1:0]         hit_rs;
  logic [NSTAGE-1:0]         hit_rt;
  logic                      slot0_md;
  logic                      slot0_div;
  logic                      issue;
  logic                      stall_int;
  logic                      md_term;
  logic                      md_busy;
  fwd_res_t                  res_rs;
  fwd_res_t                  res_rt;

  assign issue = hs.d_valid & ~stall_int;

  for (genvar i = 0; i < NSTAGE; i++) begin : g_slot
    if (i == 0) begin : g_head
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          slot_valid[0] <= 1'b0;
          slot_a3[0]    <= '0;
          slot_tnew[0]  <= '0;
        end else if (hs.flush || !issue) begin
          slot_valid[0] <= 1'b0;
          slot_a3[0]    <= '0;
          slot_tnew[0]  <= '0;
        end else begin
          slot_valid[0] <= (hs.d_a3 != '0);
          slot_a3[0]    <= hs.d_a3;
          slot_tnew[0]  <= hs.d_tnew;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          slot_valid[i] <= 1'b0;
          slot_a3[i]    <= '0;
          slot_tnew[i]  <= '0;
        end else if (hs.flush) begin
          slot_valid[i] <= 1'b0;
          slot_a3[i]    <= '0;
          slot_tnew[i]  <= '0;
        end else begin
          slot_valid[i] <= slot_valid[i-1];
          slot_a3[i]    <= slot_a3[i-1];
          slot_tnew[i]  <= (slot_tnew[i-1] == '0) ? '0 : slot_tnew[i-1] - TW'(1);
        end
      end
    end

    assign hit_rs[i] = slot_valid[i] && (slot_a3[i] == hs.d_rs);
    assign hit_rt[i] = slot_valid[i] && (slot_a3[i] == hs.d_rt);
  end

  // Only the E slot needs the MDU flag: it both triggers the counter load
  // and covers the cycle before the counter becomes nonzero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot0_md  <= 1'b0;
      slot0_div <= 1'b0;
    end else if (hs.flush || !issue) begin
      slot0_md  <= 1'b0;
      slot0_div <= 1'b0;
    end else begin
      slot0_md  <= hs.d_md_start;
      slot0_div <= hs.d_md_div;
    end
  end

  hsb_md_ctr #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_ctr (
    .clk    (clk),
    .reset  (reset),
    .load   (slot0_md & ~hs.flush),
    .is_div (slot0_div),
    .busy   (md_busy)
  );

  // Youngest matching slot decides; older matches are shadowed.
  function automatic fwd_res_t resolve(
    input logic [NSTAGE-1:0]         hit,
    input logic [NSTAGE-1:0][TW-1:0] tnew,
    input logic [TW-1:0]             tuse,
    input logic                      skip
  );
    fwd_res_t r;
    logic     found;
    r     = '{stall: 1'b0, sel: FWD_GRF};
    found = 1'b0;
    if (!skip) begin
      for (int unsigned i = 0; i < NSTAGE; i++) begin
        if (!found && hit[i]) begin
          found = 1'b1;
          if (tnew[i] > tuse)
            r.stall = 1'b1;
          else if (tnew[i] == '0)
            r.sel = fwd_code(i);
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    res_rs    = resolve(hit_rs, slot_tnew, hs.d_tuse_rs,
                        (hs.d_tuse_rs == TUSE_ALL) || (hs.d_rs == '0));
    res_rt    = resolve(hit_rt, slot_tnew, hs.d_tuse_rt,
                        (hs.d_tuse_rt == TUSE_ALL) || (hs.d_rt == '0));
    md_term   = hs.d_md_use & (md_busy | slot0_md);
    stall_int = hs.d_valid & ~hs.flush & (res_rs.stall | res_rt.stall | md_term);
  end

  assign hs.stall      = stall_int;
  assign hs.fwd_rs_sel = res_rs.sel;
  assign hs.fwd_rt_sel = res_rt.sel;
  assign hs.md_busy    = md_busy;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (NSTAGE=3, MULT_LAT=5, DIV_LAT=10)
// with hand-computed expectations for each pipeline scenario.
module tb_hazard_scoreboard;
  localparam logic [1:0] N = 2'b11;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   n;
  int   sn;

  hazard_scoreboard_if #(.RW(5), .TW(2)) hs ();

  hazard_scoreboard #(
    .NSTAGE   (3),
    .TW       (2),
    .RW       (5),
    .MULT_LAT (5),
    .DIV_LAT  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hs    (hs)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [1:0] trs,
                       input logic [4:0] rt, input logic [1:0] trt,
                       input logic [4:0] a3, input logic [1:0] tnew,
                       input logic ms, input logic mdiv, input logic mu);
    hs.d_valid    = v;
    hs.d_rs       = rs;
    hs.d_tuse_rs  = trs;
    hs.d_rt       = rt;
    hs.d_tuse_rt  = trt;
    hs.d_a3       = a3;
    hs.d_tnew     = tnew;
    hs.d_md_start = ms;
    hs.d_md_div   = mdiv;
    hs.d_md_use   = mu;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, N, 5'd0, N, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic count_busy(output int cyc, output int stalls);
    cyc    = 0;
    stalls = 0;
    while (hs.md_busy && cyc < 40) begin
      if (hs.stall) stalls++;
      cyc++;
      tick();
    end
  endtask

  initial begin
    reset    = 1'b0;
    hs.flush = 1'b0;
    drive(1'b1, 5'd3, 2'd0, 5'd3, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_stall", int'(hs.stall), 0);
    check_eq("rst_fwd_rs", int'(hs.fwd_rs_sel), 0);
    check_eq("rst_fwd_rt", int'(hs.fwd_rt_sel), 0);
    check_eq("rst_md_busy", int'(hs.md_busy), 0);
    tick();
    tick();
    reset = 1'b1;
    idle();

    // addu $3 (tnew1) then beq reading $3 at tuse0
    drive(1'b1, 5'd0, N, 5'd0, N, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_eq("t1_stall", int'(hs.stall), 1);
    check_eq("t1_fwd_rs_stalled", int'(hs.fwd_rs_sel), 0);
    tick();
    check_eq("t1_stall_rel", int'(hs.stall), 0);
    check_eq("t1_fwd_rs_m", int'(hs.fwd_rs_sel), 2);
    check_eq("t1_fwd_rt", int'(hs.fwd_rt_sel), 0);
    tick();

    // lw $5 (tnew2) then addu rs=$5 tuse1
    drive(1'b1, 5'd0, N, 5'd0, N, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd5, 2'd1, 5'd3, 2'd1, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);
    check_eq("t2_stall", int'(hs.stall), 1);
    tick();
    check_eq("t2_stall_rel", int'(hs.stall), 0);
    check_eq("t2_fwd_rs_defer", int'(hs.fwd_rs_sel), 0);
    tick();
    drive(1'b1, 5'd5, 2'd1, 5'd6, 2'd1, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);
    check_eq("t2_fwd_rs_w", int'(hs.fwd_rs_sel), 3);
    check_eq("t2_fwd_rt_defer", int'(hs.fwd_rt_sel), 0);
    check_eq("t2_no_stall", int'(hs.stall), 0);
    tick();
    drive(1'b1, 5'd6, 2'd0, 5'd7, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_eq("t2b_fwd_rs_m", int'(hs.fwd_rs_sel), 2);
    check_eq("t2b_rt_stall", int'(hs.stall), 1);
    check_eq("t2b_fwd_rt", int'(hs.fwd_rt_sel), 0);
    idle();
    tick();

    // two writers of $4 with tnew0: youngest wins, then ages out to W
    drive(1'b1, 5'd0, N, 5'd0, N, 5'd4, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 5'd4, 2'd0, 5'd4, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_eq("t3_fwd_rs_e", int'(hs.fwd_rs_sel), 1);
    check_eq("t3_fwd_rt_e", int'(hs.fwd_rt_sel), 1);
    check_eq("t3_stall", int'(hs.stall), 0);
    idle();
    tick();
    drive(1'b1, 5'd4, 2'd0, 5'd0, N, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_eq("t3_fwd_rs_m", int'(hs.fwd_rs_sel), 2);
    idle();
    tick();
    drive(1'b1, 5'd4, 2'd0, 5'd0, N, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_eq("t3_fwd_rs_w", int'(hs.fwd_rs_sel), 3);
    idle();
    tick();

    // $0 and TUSE_NONE operands never match
    drive(1'b1, 5'd0, N, 5'd0, N, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd8, N, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_eq("t4_none_stall", int'(hs.stall), 0);
    check_eq("t4_none_fwd_rs", int'(hs.fwd_rs_sel), 0);
    check_eq("t4_zero_fwd_rt", int'(hs.fwd_rt_sel), 0);
    drive(1'b1, 5'd8, 2'd1, 5'd0, N, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_eq("t4_live_stall", int'(hs.stall), 1);
    idle();
    tick();
    tick();
    tick();

    // div then mflo, then mult stalled on a GPR dependency
    drive(1'b1, 5'd0, N, 5'd0, N, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    check_eq("t5_div_issue", int'(hs.stall), 0);
    tick();
    drive(1'b1, 5'd0, N, 5'd0, N, 5'd9, 2'd1, 1'b0, 1'b0, 1'b1);
    check_eq("t5_mflo_stall_e", int'(hs.stall), 1);
    check_eq("t5_busy_pre", int'(hs.md_busy), 0);
    tick();
    check_eq("t5_busy_load", int'(hs.md_busy), 1);
    count_busy(n, sn);
    check_eq("t5_div_busy_cyc", n, 10);
    check_eq("t5_div_stall_cyc", sn, 10);
    check_eq("t5_mflo_go", int'(hs.stall), 0);
    tick();
    drive(1'b1, 5'd9, 2'd0, 5'd0, N, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    check_eq("t5_mult_stall", int'(hs.stall), 1);
    tick();
    check_eq("t5_mult_go", int'(hs.stall), 0);
    check_eq("t5_mult_fwd_rs", int'(hs.fwd_rs_sel), 2);
    check_eq("t5_no_load_on_stall", int'(hs.md_busy), 0);
    tick();
    idle();
    check_eq("t5_mult_in_e", int'(hs.md_busy), 0);
    tick();
    count_busy(n, sn);
    check_eq("t5_mult_busy_cyc", n, 5);

    // flush during a dependency stall while the MDU is running
    drive(1'b1, 5'd0, N, 5'd0, N, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    tick();
    check_eq("t6_busy", int'(hs.md_busy), 1);
    drive(1'b1, 5'd0, N, 5'd0, N, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd10, 2'd0, 5'd0, N, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_eq("t6_dep_stall", int'(hs.stall), 1);
    hs.flush = 1'b1;
    #1;
    check_eq("t6_flush_stall", int'(hs.stall), 0);
    check_eq("t6_flush_busy", int'(hs.md_busy), 1);
    tick();
    hs.flush = 1'b0;
    #1;
    check_eq("t6_post_stall", int'(hs.stall), 0);
    check_eq("t6_post_fwd_rs", int'(hs.fwd_rs_sel), 0);
    count_busy(n, sn);
    check_eq("t6_busy_left", n, 8);

    // asynchronous reset with a mult sitting in E
    drive(1'b1, 5'd0, N, 5'd0, N, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 5'd0, N, 5'd0, N, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    check_eq("r_pre_stall", int'(hs.stall), 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("r_stall", int'(hs.stall), 0);
    check_eq("r_busy", int'(hs.md_busy), 0);
    tick();
    reset = 1'b1;
    idle();
    tick();
    check_eq("r_no_load", int'(hs.md_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
